// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants and state type for the filter-bank channel serializer
package fb_pkg;

    localparam int NCH       = 16;            // filter-bank channels
    localparam int IN_W      = 33;            // signed channel input width
    localparam int OUT_W_DEF = 16;            // default requantized width
    localparam int SHIFT_DEF = 17;            // default requantization shift
    localparam int CH_W      = $clog2(NCH);   // channel index width

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/fb_requant.sv
// rtl/fb_requant.sv - combinational round-half-up, arithmetic shift and saturate
// Ports:
//   x : signed IN_W-bit input sample
//   y : signed OUT_W-bit requantized sample
module fb_requant #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16,
    parameter int SHIFT = 17
) (
    input  logic signed [IN_W-1:0]  x,
    output logic signed [OUT_W-1:0] y
);

    localparam logic        [IN_W:0] HALF  = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAX_V = {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = {{(IN_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [IN_W:0] t;
    logic signed [IN_W:0] s;

    // One guard bit keeps the rounding addition from wrapping at the positive limit.
    always_comb begin
        t = $signed({x[IN_W-1], x}) + $signed(HALF);
        s = t >>> SHIFT;
        if (s > MAX_V) begin
            y = MAX_V[OUT_W-1:0];
        end else if (s < MIN_V) begin
            y = MIN_V[OUT_W-1:0];
        end else begin
            y = s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fb_channel_serializer.sv
// rtl/fb_channel_serializer.sv - decimating snapshot of filter-bank channels streamed one per transfer
// Ports:
//   clock, reset           : clock, asynchronous active-high reset
//   clk_enable             : sample strobe shared with the filter bank
//   ch_in                  : NCH flattened signed channel samples, channel k at [k*IN_W +: IN_W]
//   out_data/out_chan      : requantized sample and its channel index
//   out_valid/out_ready    : stream handshake
//   out_last               : marks the word for channel NCH-1
//   overrun / overrun_clr  : sticky dropped-snapshot flag and its synchronous clear
module fb_channel_serializer
    import fb_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int DECIM = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clk_enable,
    input  logic [NCH*IN_W-1:0]    ch_in,
    output logic [OUT_W-1:0]       out_data,
    output logic [CH_W-1:0]        out_chan,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam int              CNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [CH_W-1:0]  IDX_LAST = CH_W'(NCH - 1);

    logic [CNT_W-1:0] dec_cnt;
    logic             capture;
    logic [OUT_W-1:0] rq   [NCH];
    logic [OUT_W-1:0] snap [NCH];

    state_t           state, next_state;
    logic [CH_W-1:0]  idx, next_idx;
    logic             load_snap;
    logic             drop;
    logic             final_hs;

    for (genvar k = 0; k < NCH; k++) begin : g_rq
        fb_requant #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W),
            .SHIFT (SHIFT)
        ) u_rq (
            .x (ch_in[k*IN_W +: IN_W]),
            .y (rq[k])
        );
    end

    assign capture = clk_enable && (dec_cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dec_cnt <= '0;
        end else if (clk_enable) begin
            dec_cnt <= (dec_cnt == CNT_LAST) ? '0 : dec_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    // A capture landing on the final handshake chains straight into the next
    // stream; any other capture while streaming is dropped.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        load_snap  = 1'b0;
        drop       = 1'b0;
        final_hs   = (state == STREAM) && out_ready && (idx == IDX_LAST);
        unique case (state)
            IDLE: begin
                if (capture) begin
                    load_snap  = 1'b1;
                    next_idx   = '0;
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (idx == IDX_LAST) begin
                        next_idx   = '0;
                        next_state = IDLE;
                    end else begin
                        next_idx = idx + 1'b1;
                    end
                end
                if (capture) begin
                    if (final_hs) begin
                        load_snap  = 1'b1;
                        next_state = STREAM;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                snap[k] <= '0;
            end
        end else if (load_snap) begin
            for (int k = 0; k < NCH; k++) begin
                snap[k] <= rq[k];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    assign out_valid = (state == STREAM);
    assign out_chan  = idx;
    assign out_data  = snap[idx];
    assign out_last  = out_valid && (idx == IDX_LAST);

endmodule

// File: tb/tb_fb_channel_serializer.sv
// tb/tb_fb_channel_serializer.sv - self-checking bench for fb_channel_serializer
module tb_fb_channel_serializer;

    localparam int NCH   = 16;
    localparam int IN_W  = 33;
    localparam int OUT_W = 16;
    localparam int SHIFT = 17;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                clk_enable = 1'b0;
    logic [NCH*IN_W-1:0] ch_in = '0;
    logic                out_ready = 1'b0;
    logic                overrun_clr = 1'b0;

    logic [OUT_W-1:0] d4_data, d1_data, d16_data;
    logic [3:0]       d4_chan, d1_chan, d16_chan;
    logic             d4_valid, d1_valid, d16_valid;
    logic             d4_last, d1_last, d16_last;
    logic             d4_ovr, d1_ovr, d16_ovr;

    always #5 clock = ~clock;

    fb_channel_serializer #(.OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(4)) u_d4 (
        .clock(clock), .reset(reset), .clk_enable(clk_enable), .ch_in(ch_in),
        .out_data(d4_data), .out_chan(d4_chan), .out_valid(d4_valid), .out_ready(out_ready),
        .out_last(d4_last), .overrun(d4_ovr), .overrun_clr(overrun_clr));

    fb_channel_serializer #(.OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(1)) u_d1 (
        .clock(clock), .reset(reset), .clk_enable(clk_enable), .ch_in(ch_in),
        .out_data(d1_data), .out_chan(d1_chan), .out_valid(d1_valid), .out_ready(out_ready),
        .out_last(d1_last), .overrun(d1_ovr), .overrun_clr(overrun_clr));

    fb_channel_serializer #(.OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(16)) u_d16 (
        .clock(clock), .reset(reset), .clk_enable(clk_enable), .ch_in(ch_in),
        .out_data(d16_data), .out_chan(d16_chan), .out_valid(d16_valid), .out_ready(out_ready),
        .out_last(d16_last), .overrun(d16_ovr), .overrun_clr(overrun_clr));

    // Instance under test: 0 -> DECIM 4, 1 -> DECIM 1, 2 -> DECIM 16
    int               sel = 0;
    logic [OUT_W-1:0] o_data;
    logic [3:0]       o_chan;
    logic             o_valid, o_last, o_ovr;

    always_comb begin
        o_data = d4_data; o_chan = d4_chan; o_valid = d4_valid; o_last = d4_last; o_ovr = d4_ovr;
        if (sel == 1) begin
            o_data = d1_data; o_chan = d1_chan; o_valid = d1_valid; o_last = d1_last; o_ovr = d1_ovr;
        end else if (sel == 2) begin
            o_data = d16_data; o_chan = d16_chan; o_valid = d16_valid; o_last = d16_last; o_ovr = d16_ovr;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pos = words already delivered from the current snapshot (NCH = idle)
    longint chv    [NCH];
    longint m_snap [NCH];
    int     m_pos;
    int     m_en;
    int     m_decim;
    bit     m_ovr;
    longint lit_tab [4];
    int     lit_n = 0;

    function automatic longint ref_rq(longint x);
        longint t, q, div;
        div = longint'(1) << SHIFT;
        t = x + (longint'(1) << (SHIFT - 1));
        q = t / div;
        if (t < 0 && (t % div) != 0) q = q - 1;   // floor division
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    function automatic longint rand33();
        longint r;
        r = {$urandom, $urandom};
        return (r <<< 31) >>> 31;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_ch();
        for (int k = 0; k < NCH; k++) ch_in[k*IN_W +: IN_W] = chv[k][IN_W-1:0];
    endtask

    task automatic model_reset(input int decim);
        m_pos = NCH; m_en = 0; m_ovr = 1'b0; m_decim = decim;
        for (int k = 0; k < NCH; k++) m_snap[k] = 0;
    endtask

    task automatic do_reset(input int decim);
        reset = 1'b1;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_last", o_last, 0);
        chk("rst_ovr", o_ovr, 0);
        chk("rst_chan", o_chan, 0);
        chk("rst_data", o_data, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset(decim);
    endtask

    // Advance one clock with the current inputs, updating the model, then compare.
    task automatic cycle();
        bit busy, hs, fin, cap, drop;
        busy = m_pos < NCH;
        hs   = busy && out_ready;
        fin  = hs && (m_pos == NCH - 1);
        cap  = clk_enable && ((m_en % m_decim) == m_decim - 1);
        drop = cap && busy && !fin;
        if (clk_enable) m_en++;
        if (hs) m_pos++;
        if (cap && !drop) begin
            for (int k = 0; k < NCH; k++) m_snap[k] = ref_rq(chv[k]);
            m_pos = 0;
        end
        if (drop) m_ovr = 1'b1;
        else if (overrun_clr) m_ovr = 1'b0;
        @(posedge clock); #1;
        chk("valid", o_valid, longint'(m_pos < NCH));
        chk("last", o_last, longint'(m_pos == NCH - 1));
        chk("overrun", o_ovr, longint'(m_ovr));
        if (m_pos < NCH) begin
            chk("chan", o_chan, m_pos);
            chk("data", longint'($signed(o_data)), m_snap[m_pos]);
            if (m_pos < lit_n) chk("lit_data", longint'($signed(o_data)), lit_tab[m_pos]);
        end
    endtask

    initial begin
        model_reset(4);
        #2;
        // Reset / decimation: all channels 131072 -> every word 1
        sel = 0;
        for (int k = 0; k < NCH; k++) chv[k] = 131072;
        drive_ch();
        do_reset(4);
        clk_enable = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("no_valid_before_4th", o_valid, 0);
        cycle();
        chk("valid_after_4th", o_valid, 1);
        chk("first_word", longint'($signed(o_data)), 1);
        for (int i = 0; i < 20; i++) cycle();

        // Rounding boundaries
        chv[0] = 65536; chv[1] = -65536; chv[2] = 196607; chv[3] = -131073;
        lit_tab[0] = 1; lit_tab[1] = 0; lit_tab[2] = 1; lit_tab[3] = -1; lit_n = 4;
        for (int k = 4; k < NCH; k++) chv[k] = rand33();
        drive_ch();
        do_reset(4);
        for (int i = 0; i < 24; i++) cycle();

        // Saturation boundaries
        chv[0] = 64'sd4294967295; chv[1] = -64'sd4294967296; chv[2] = 64'sd2147483648;
        lit_tab[0] = 32767; lit_tab[1] = -32768; lit_tab[2] = 16384; lit_n = 3;
        drive_ch();
        do_reset(4);
        for (int i = 0; i < 24; i++) cycle();
        lit_n = 0;

        // Random data, strobe, backpressure and clears
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NCH; k++) chv[k] = rand33();
            drive_ch();
            clk_enable  = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 1) != 0);
            overrun_clr = ($urandom_range(0, 15) == 0);
            cycle();
        end
        overrun_clr = 1'b0;

        // Overrun with DECIM 1 and a stalled sink
        sel = 1;
        clk_enable = 1'b1; out_ready = 1'b0;
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < NCH; k++) chv[k] = rand33();
            drive_ch();
            cycle();
        end
        chk("ovr_set", o_ovr, 1);
        clk_enable = 1'b0; overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        chk("ovr_cleared", o_ovr, 0);
        cycle();

        // Back-to-back with DECIM 16, then reset mid-stream
        sel = 2;
        clk_enable = 1'b1; out_ready = 1'b1;
        do_reset(16);
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < NCH; k++) chv[k] = rand33();
            drive_ch();
            cycle();
        end
        chk("b2b_no_ovr", o_ovr, 0);
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                if (o_valid && o_chan == 4'd7) found = 1'b1;
                else cycle();
            end
            chk("reach_idx7", found, 1);
        end
        do_reset(16);
        for (int i = 0; i < 15; i++) cycle();
        chk("no_restart_early", o_valid, 0);
        cycle();
        chk("restart_after_16", o_valid, 1);
        chk("restart_chan0", o_chan, 0);
        for (int i = 0; i < 4; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_channel_serializer.md
Name: fb_channel_serializer

Overview:
- Sits directly downstream of the 16-channel parallel filter bank and consumes its 16 parallel channel outputs.
- Decimates by DECIM: every DECIM-th enabled sample it captures a snapshot of all channels and requantizes each one (round, shift, saturate).
- Streams the snapshot out one channel per transfer over a valid/ready interface to the sub-band processing or packetizer stage.
- Flags snapshots that are dropped because the previous stream has not finished.

Parameters:
- NCH, 16, number of filter-bank channels.
- IN_W, 33, signed width of each channel input.
- OUT_W, 16, signed width of each output sample.
- SHIFT, 17, right-shift applied during requantization; legal range 1..IN_W-1.
- DECIM, 4, decimation factor in enabled samples; legal range >=1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_enable  in  1  sample strobe; same strobe that advances the filter bank.
- ch_in  in  NCH*IN_W  channel outputs, flattened; channel k occupies bits [k*IN_W +: IN_W].
- out_data  out  OUT_W  requantized sample of channel out_chan.
- out_chan  out  4 (clog2 NCH)  channel index of out_data.
- out_valid  out  1  out_data, out_chan and out_last are valid.
- out_ready  in  1  downstream accepts the current word.
- out_last  out  1  high on the word for channel NCH-1.
- overrun  out  1  sticky: a snapshot was dropped.
- overrun_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset is reset (asynchronous, active-high); clock is clock. Reset values: out_valid=0, out_chan=0, out_data=0, out_last=0, overrun=0, decimation counter=0, snapshot buffer all 0, state=IDLE.
- Decimation counter:
  - Advances only when clk_enable=1; wraps DECIM-1 -> 0.
  - A capture event occurs in a cycle where clk_enable=1 and the counter = DECIM-1.
  - So the first capture is on the DECIM-th enabled cycle after reset.
- Capture: on the capture edge each ch_in[k] is requantized and written to buf[k], storing NCH*OUT_W bits.
- Requantization, per channel:
  - t = x + 2^(SHIFT-1), computed in IN_W+1 bits.
  - y = t >>> SHIFT (arithmetic shift).
  - Saturate y to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - The result is round-half-up with saturation.
- FSM IDLE:
  - out_valid=0.
  - On a capture event: load buf, idx=0, go to STREAM. out_valid=1 from the next cycle, so latency is 1 cycle from the capture edge.
- FSM STREAM:
  - out_valid=1, out_chan=idx, out_data=buf[idx], out_last=(idx==NCH-1).
  - Outputs hold stable while out_ready=0.
  - On out_valid & out_ready: if idx<NCH-1, idx++; otherwise go to IDLE.
- Capture event in STREAM, not on the final handshake: the snapshot is dropped, buf is untouched, the current stream continues unchanged, and overrun is set.
- Capture event coinciding with the final handshake (idx=NCH-1 and out_ready=1): buf is reloaded, idx=0, state stays STREAM, out_valid stays 1, and there is no overrun.
- overrun:
  - Stays set until overrun_clr=1.
  - If a set event and overrun_clr occur in the same cycle, set wins.
- The output handshake is independent of clk_enable; streaming proceeds while clk_enable=0.
- Reset asserted mid-stream: everything returns to reset values immediately, and the partially streamed snapshot is discarded.
- Throughput: with out_ready held at 1, a stream takes NCH cycles. Configurations with DECIM*(enable period) < NCH are guaranteed to overrun.

Decomposition:
- Shared package fb_pkg holds NCH, IN_W, the default OUT_W/SHIFT, the channel-index width constant, and the state enum (IDLE, STREAM).
- One natural sub-module, fb_requant: purely combinational round/shift/saturate, parameterised by IN_W, OUT_W and SHIFT, instantiated NCH times via generate.

Test Plan:
- Reset/decimation: DECIM=4, clk_enable=1 continuously, all channels = 131072 -> out_valid rises 1 cycle after the 4th enabled edge; 16 words, each out_data=1; out_chan 0..15; out_last only on channel 15.
- Rounding: ch0=65536, ch1=-65536, ch2=196607, ch3=-131073 -> out_data 1, 0, 1, -1 respectively.
- Saturation: ch0=2^32-1, ch1=-2^32, ch2=2^31 -> 32767, -32768, 16384.
- Backpressure: toggle out_ready 1,0,0,1 randomly during a stream -> out_data/out_chan stable while ready=0; all 16 channels delivered in order exactly once.
- Overrun: DECIM=1, clk_enable=1, out_ready=0 -> overrun=1 after the second capture, channel-0 word unchanged; pulse overrun_clr with no new drop -> overrun=0 next cycle.
- Back-to-back: DECIM=16, clk_enable=1, out_ready=1 -> final handshake coincides with the capture; the next stream starts with channel 0 with no out_valid gap and overrun=0. Assert reset at idx=7 -> out_valid=0 immediately and the stream restarts only after 16 new enabled samples.
